// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the integer write-back path:
//                register address width, register count, default data width
//                and the packed queue entry (destination + result).
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  // One pending register-file write: destination register and its value
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : Synchronous FIFO of wb_entry_t with two ordered write ports
//                (port 0 lands ahead of port 1 in the same cycle), one read
//                port with a combinational head, and an occupancy count.
//                The caller guarantees it never pushes more than the free
//                room; a pop on an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr0_en,
  input  wb_entry_t                i_wr0_data,
  input  logic                     i_wr1_en,
  input  wb_entry_t                i_wr1_data,
  input  logic                     i_rd_en,
  output wb_entry_t                o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  wb_entry_t            r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;

  logic [c_ptr_w-1:0]   w_wr1_slot;
  logic [1:0]           w_n_wr;
  logic                 w_pop;

  // Port 1 sits directly behind port 0 when both write, otherwise at the tail
  assign w_wr1_slot = i_wr0_en ? (r_wr_ptr + c_ptr_w'(1)) : r_wr_ptr;
  assign w_n_wr     = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
  assign w_pop      = i_rd_en & (r_count != '0);

  // Storage array: data only, no reset needed since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (i_wr0_en) r_mem[r_wr_ptr]   <= i_wr0_data;
    if (i_wr1_en) r_mem[w_wr1_slot] <= i_wr1_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power of two)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + c_ptr_w'(w_n_wr);
      r_rd_ptr <= r_rd_ptr + c_ptr_w'(w_pop);
      r_count  <= r_count + c_cnt_w'(w_n_wr) - c_cnt_w'(w_pop);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
//  Module      : wb_writer
//  Description : Integer register-file write-back stage. Accepts ALU and LSU
//                results, queues them (LSU ahead of ALU when both arrive),
//                drains one write per cycle to the register bank and keeps a
//                per-register busy scoreboard (set at issue, cleared at
//                write-back). Writes to x0 are accepted and dropped.
//  Config      : WB_BYPASS_EN - when defined, a result arriving at an empty
//                queue is written to the register file in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_writer
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,  // must match the queue entry data width
  parameter int DEPTH = 4              // power of two, >= 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     issue_valid,
  input  logic [REG_ADDR_W-1:0]    issue_rd,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_ADDR_W-1:0]    alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REG_ADDR_W-1:0]    lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  output logic [REG_ADDR_W-1:0]    rd,
  output logic                     rd_write_control,
  output logic [XLEN-1:0]          rd_write_val,
  output logic [NUM_REGS-1:0]      busy,
  output logic [$clog2(DEPTH):0]   wb_count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [c_cnt_w-1:0]  w_count;
  logic [c_cnt_w-1:0]  w_free;
  logic [c_cnt_w-1:0]  w_alu_need;
  logic                w_empty;
  logic                w_lsu_nz;
  logic                w_alu_nz;
  logic                w_lsu_acc;
  logic                w_alu_acc;
  logic                w_byp_lsu;
  logic                w_byp_alu;
  logic                w_lsu_enq;
  logic                w_alu_enq;
  logic                w_push0;
  logic                w_push1;
  wb_entry_t           w_lsu_entry;
  wb_entry_t           w_alu_entry;
  wb_entry_t           w_data0;
  wb_entry_t           w_head;
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  assign w_lsu_entry = '{rd: lsu_rd, data: lsu_data};
  assign w_alu_entry = '{rd: alu_rd, data: alu_data};

  // Only nonzero destinations ever occupy a queue slot
  assign w_lsu_nz = lsu_valid & (lsu_rd != '0);
  assign w_alu_nz = alu_valid & (alu_rd != '0);

  // Room is judged on the registered count; the same-cycle pop is not credited
  assign w_free     = c_cnt_w'(DEPTH) - w_count;
  assign w_alu_need = c_cnt_w'(1) + c_cnt_w'(w_lsu_nz);
  assign lsu_ready  = (lsu_rd == '0) | (w_free >= c_cnt_w'(1));
  assign alu_ready  = (alu_rd == '0) | (w_free >= w_alu_need);

  assign w_lsu_acc = w_lsu_nz & lsu_ready;
  assign w_alu_acc = w_alu_nz & alu_ready;

`ifdef WB_BYPASS_EN
  // Empty queue: LSU result goes straight through, else the ALU result
  assign w_byp_lsu = w_empty & w_lsu_acc;
  assign w_byp_alu = w_empty & w_alu_acc & ~w_lsu_acc;
`else
  assign w_byp_lsu = 1'b0;
  assign w_byp_alu = 1'b0;
`endif

  assign w_lsu_enq = w_lsu_acc & ~w_byp_lsu;
  assign w_alu_enq = w_alu_acc & ~w_byp_alu;

  // Compact the two sources onto the ordered write ports: LSU first
  assign w_push0 = w_lsu_enq | w_alu_enq;
  assign w_data0 = w_lsu_enq ? w_lsu_entry : w_alu_entry;
  assign w_push1 = w_lsu_enq & w_alu_enq;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr0_en   (w_push0),
    .i_wr0_data (w_data0),
    .i_wr1_en   (w_push1),
    .i_wr1_data (w_alu_entry),
    .i_rd_en    (~w_empty),
    .o_rd_data  (w_head),
    .o_count    (w_count)
  );

  assign w_empty  = (w_count == '0);
  assign empty    = w_empty;
  assign full     = (w_count == c_cnt_w'(DEPTH));
  assign wb_count = w_count;

  // Register-file write port: queue head when occupied, else bypass or idle
  always_comb begin
    rd               = '0;
    rd_write_val     = '0;
    rd_write_control = 1'b0;
    if (!w_empty) begin
      rd               = w_head.rd;
      rd_write_val     = w_head.data;
      rd_write_control = 1'b1;
    end else if (w_byp_lsu) begin
      rd               = lsu_rd;
      rd_write_val     = lsu_data;
      rd_write_control = 1'b1;
    end else if (w_byp_alu) begin
      rd               = alu_rd;
      rd_write_val     = alu_data;
      rd_write_control = 1'b1;
    end
  end

  // Scoreboard update: clear on write-back, then set on issue so set wins
  always_comb begin
    w_busy_next = r_busy;
    if (rd_write_control) w_busy_next[rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) w_busy_next[issue_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign busy = r_busy;

endmodule
`default_nettype wire
